// File: rtl/tx_encode_interleave_if.sv
// tx_encode_interleave_if: request/result bundle between a block source and the encoder.
interface tx_encode_interleave_if #(parameter int DATA_W = 64, parameter int OUT_W = 128);
  logic start;
  logic ilv_en;
  logic [DATA_W-1:0] data_in;
  logic busy;
  logic done;
  logic [OUT_W-1:0] final_output;
  modport master(output start, ilv_en, data_in, input busy, done, final_output);
  modport slave(input start, ilv_en, data_in, output busy, done, final_output);
endinterface

// File: rtl/tx_encode_interleave.sv
// tx_encode_interleave: GF(2) block encoder, one K-bit word per cycle, then optional row/column interleave.
module tx_encode_interleave #(
  parameter int DATA_W = 64,
  parameter int K = 4,
  parameter int N = 8,
  parameter logic [K*N-1:0] GEN = 32'h78B4D2E1,
  parameter int ROWS = 8
) (
  input logic clk,
  input logic reset,
  tx_encode_interleave_if.slave bus
);
  localparam int WORDS = DATA_W / K;
  localparam int OUT_W = WORDS * N;
  localparam int COLS = OUT_W / ROWS;
  localparam int CW = WORDS > 1 ? $clog2(WORDS) : 1;
  typedef enum logic [1:0] {IDLE, ENCODE, EMIT} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic ilv_q, ilv_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] e_q, e_d, out_q, out_d, ilv_v;
  logic done_q, done_d;
  logic [K-1:0] m;
  logic [N-1:0] cw;
  logic last;
  assign last = cnt_q == CW'(WORDS - 1);
  always_comb begin
    m = data_q[int'(cnt_q)*K +: K];
    cw = '0;
    for (int j = 0; j < N; j++)
      for (int k = 0; k < K; k++)
        cw[j] = cw[j] ^ (m[k] & GEN[k*N+j]);
  end
  // E is written row-major; the interleaved block reads it column by column
  always_comb begin
    ilv_v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        ilv_v[c*ROWS+r] = e_q[r*COLS+c];
  end
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    ilv_d = ilv_q;
    cnt_d = cnt_q;
    e_d = e_q;
    out_d = out_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = ENCODE;
        data_d = bus.data_in;
        ilv_d = bus.ilv_en;
        cnt_d = '0;
        e_d = '0;
      end
      ENCODE: begin
        e_d[int'(cnt_q)*N +: N] = cw;
        cnt_d = last ? '0 : cnt_q + 1'b1;
        state_d = last ? EMIT : ENCODE;
      end
      EMIT: begin
        out_d = ilv_q ? ilv_v : e_q;
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q <= '0;
      ilv_q <= 1'b0;
      cnt_q <= '0;
      e_q <= '0;
      out_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      ilv_q <= ilv_d;
      cnt_q <= cnt_d;
      e_q <= e_d;
      out_q <= out_d;
      done_q <= done_d;
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  assign bus.final_output = out_q;
endmodule

// File: tb/tb_tx_encode_interleave.sv
// tb_tx_encode_interleave: directed and model-checked blocks through the encoder/interleaver.
module tb_tx_encode_interleave;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  tx_encode_interleave_if bus ();
  tx_encode_interleave dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model(input logic [63:0] d, input bit il);
    logic [31:0] g;
    logic [127:0] e, o;
    logic [3:0] m;
    g = 32'h78B4D2E1;
    e = '0;
    for (int i = 0; i < 16; i++) begin
      m = d[i*4 +: 4];
      for (int j = 0; j < 8; j++)
        for (int k = 0; k < 4; k++)
          e[i*8+j] = e[i*8+j] ^ (m[k] & g[k*8+j]);
    end
    o = e;
    if (il)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 16; c++)
          o[c*8+r] = e[r*16+c];
    return o;
  endfunction

  // Called at #1 after an edge with the DUT idle; returns at #1 after the done edge.
  task automatic block(input logic [63:0] d, input bit il, input bit poke,
                       output logic [127:0] got, output int lat, output int bcnt);
    bus.start = 1'b1;
    bus.data_in = d;
    bus.ilv_en = il;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.data_in = ~d;
    bus.ilv_en = ~il;
    lat = 0;
    bcnt = 0;
    while (!bus.done && lat < 40) begin
      bcnt += int'(bus.busy);
      bus.start = poke && lat == 5;
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    got = bus.final_output;
  endtask

  logic [127:0] got, held;
  int lat, bcnt, kk, ndone;
  logic [63:0] pats [60];
  bit ils [60];

  initial begin
    bus.start = 1'b0;
    bus.ilv_en = 1'b0;
    bus.data_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", 128'(bus.busy), 0);
    chk("rst_done", 128'(bus.done), 0);
    chk("rst_out", bus.final_output, 0);

    block(64'h0, 1'b1, 1'b0, got, lat, bcnt);
    chk("zero_out", got, 128'h0);
    chk("zero_lat", 128'(lat), 17);
    chk("zero_busy", 128'(bcnt), 17);

    block(64'h1, 1'b0, 1'b0, got, lat, bcnt);
    chk("one_byp", got, 128'hE1);
    held = got;
    @(posedge clk); #1;
    chk("done_pulse", 128'(bus.done), 0);
    repeat (2) @(posedge clk);
    #1 chk("out_hold", bus.final_output, held);

    block(64'h1, 1'b1, 1'b0, got, lat, bcnt);
    chk("one_ilv", got, 128'h0000_0000_0000_0000_0101_0100_0000_0001);
    block(64'h2, 1'b0, 1'b0, got, lat, bcnt);
    chk("two_byp", got, 128'hD2);
    block(64'h10, 1'b0, 1'b0, got, lat, bcnt);
    chk("word1_byp", got, 128'hE100);
    block(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, got, lat, bcnt);
    chk("ones_byp", got, {128{1'b1}});
    block(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, got, lat, bcnt);
    chk("ones_ilv", got, {128{1'b1}});

    block(64'h1, 1'b0, 1'b1, got, lat, bcnt);
    chk("busy_start_out", got, 128'hE1);
    chk("busy_start_lat", 128'(lat), 17);
    @(posedge clk); #1;
    chk("busy_start_noq", 128'(bus.busy), 0);

    for (int n = 0; n < 60; n++) begin
      pats[n] = {$urandom, $urandom};
      ils[n] = 1'($urandom_range(0, 1));
    end
    kk = 0;
    for (int n = 0; n < 60; n++) begin
      bus.start = 1'b1;
      bus.data_in = pats[n];
      bus.ilv_en = ils[n];
      @(posedge clk); #1;
      if (bus.done) begin
        chk("b2b_pos", 128'(n), 128'(17 + 18 * kk));
        chk("b2b_out", bus.final_output, n >= 17 ? model(pats[n-17], ils[n-17]) : 128'hx);
        kk++;
      end
    end
    bus.start = 1'b0;
    chk("b2b_count", 128'(kk), 3);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;

    bus.start = 1'b1;
    bus.data_in = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.ilv_en = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("abort_busy", 128'(bus.busy), 0);
    chk("abort_done", 128'(bus.done), 0);
    chk("abort_out", bus.final_output, 0);
    ndone = 0;
    repeat (20) begin
      @(posedge clk); #1;
      ndone += int'(bus.done);
    end
    chk("abort_nodone", 128'(ndone), 0);
    block(64'h1, 1'b0, 1'b0, got, lat, bcnt);
    chk("after_abort_out", got, 128'hE1);
    chk("after_abort_lat", 128'(lat), 17);

    for (int i = 0; i < 1000; i++) begin
      logic [63:0] d;
      bit il;
      d = {$urandom, $urandom};
      il = 1'($urandom_range(0, 1));
      block(d, il, 1'b0, got, lat, bcnt);
      chk("rand_out", got, model(d, il));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tx_encode_interleave.md
TX_ENCODE_INTERLEAVE -- requirements
Module: tx_encode_interleave

Interface
REQ-001 Parameter DATA_W, default 64: message bits accepted per block; SHALL be a multiple of K.
REQ-002 Parameter K, default 4: message bits per codeword.
REQ-003 Parameter N, default 8: codeword bits; N >= K.
REQ-004 Parameter GEN, default 32'h78B4D2E1, width K*N: generator matrix; row k = GEN[k*N +: N].
REQ-005 Parameter ROWS, default 8: interleaver rows; OUT_W SHALL be a multiple of ROWS.
REQ-006 Derived: WORDS = DATA_W/K (16), OUT_W = WORDS*N (128), COLS = OUT_W/ROWS (16).
REQ-007 clk  input  1  single clock; all state updates on the rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 start  input  1  request to encode data_in; qualified by busy=0.
REQ-010 ilv_en  input  1  1 = interleave, 0 = bypass; sampled with start.
REQ-011 data_in  input  DATA_W  message block; sampled with start.
REQ-012 busy  output  1  block in progress; start ignored while high.
REQ-013 done  output  1  one-cycle pulse, final_output valid.
REQ-014 final_output  output  OUT_W  encoded, optionally interleaved block; held until next done.

Function
REQ-015 States: IDLE, ENCODE, EMIT; busy=1 in ENCODE and EMIT only.
REQ-016 IDLE: start=1 at edge T0 -> capture data_in and ilv_en, clear word counter and codeword buffer E, go to ENCODE.
REQ-017 ENCODE: at edge T0+1+i (i = 0..WORDS-1), encode m = data_in_q[i*K +: K] into E[i*N +: N]; one word per cycle.
REQ-018 Codeword over GF(2): c[j] = XOR over k of (m[k] AND GEN[k*N+j]), j = 0..N-1.
REQ-019 After word WORDS-1, go to EMIT; counter wraps to 0, never exceeds WORDS-1.
REQ-020 EMIT: ilv_en_q=1 -> final_output[c*ROWS+r] = E[r*COLS+c] (write row-major, read column-major); ilv_en_q=0 -> final_output = E.
REQ-021 At edge T0+WORDS+1: final_output registered, done=1 for exactly one cycle, state returns to IDLE, busy=0.
REQ-022 Latency start-sample to done = WORDS+1 cycles (17 with defaults); throughput one block per WORDS+2 cycles.
REQ-023 start while busy=1 is ignored: no capture, no effect on the block in flight, no queuing.
REQ-024 start may be sampled in the cycle done=1 (state IDLE); back-to-back blocks SHALL not corrupt the emitted final_output.
REQ-025 Changes on data_in/ilv_en after T0 SHALL not affect the block in flight.
REQ-026 final_output changes only at the edge where done is asserted.

Reset
REQ-027 reset=1 at an edge -> state IDLE, busy=0, done=0, final_output=0, E=0, counter=0; overrides start in the same cycle.
REQ-028 reset mid-ENCODE or EMIT aborts the block: no done pulse; next start after reset is processed normally.

Verification
REQ-029 data_in=0, ilv_en=1, start pulse -> done exactly 17 cycles later, final_output=128'h0, busy high 17 cycles.
REQ-030 data_in=64'h1, ilv_en=0 -> final_output=128'hE1; ilv_en=1 -> final_output=128'h0000_0000_0000_0000_0101_0100_0000_0001.
REQ-031 data_in=64'hFFFF_FFFF_FFFF_FFFF, either ilv_en -> final_output all ones (each codeword 8'hFF).
REQ-032 start held high continuously with changing data_in -> one block per 18 cycles, each result matching data_in sampled in its accepting cycle.
REQ-033 reset asserted at cycle 8 of ENCODE -> no done, outputs 0; fresh start with data_in=64'h1, ilv_en=0 -> 128'hE1 after 17 cycles.
REQ-034 Random data_in/ilv_en, 1000 blocks -> final_output matches a bit-exact reference model of REQ-018/REQ-020.
